// File: rtl/sm4_mode_engine_pkg.sv
// Shared SM4 constants, state/mode enums and word helpers for the mode engine.
// Rounds and key expansion operate on [3:0][31:0] word vectors, with word 0 being the oldest.
package sm4_mode_engine_pkg;

  localparam int group_size_p = 128;
  localparam int word_width_p = 32;

  localparam logic [127:0] key_xor_mask = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  typedef enum logic [1:0] {eIdle, eKeyExp, eCrypt, eDone} state_e;
  typedef enum logic [1:0] {eECB, eCBC, eCTR, eRsvd} mode_e;

  // CK word i: byte j is (4i+j)*7 mod 256, most significant byte first.
  function automatic logic [31:0] key_aux(input logic [4:0] i);
    logic [31:0] ck;
    for (int b = 0; b < 4; b++) ck[31-8*b -: 8] = 8'((4 * int'(i) + b) * 7);
    return ck;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [3:0][31:0] to_words(input logic [127:0] b);
    return {b[31:0], b[63:32], b[95:64], b[127:96]};
  endfunction

endpackage

// File: rtl/sm4_round.sv
// One combinational SM4 round: y = x0 ^ T(x1^x2^x3^rk), using T' when expanding keys.
module sm4_round
  import sm4_mode_engine_pkg::*;
(
  input  logic [3:0][word_width_p-1:0] x_i,
  input  logic [word_width_p-1:0]      rk_i,
  input  logic                         is_key_i,
  output logic [word_width_p-1:0]      y_o
);

  logic [31:0] a, b;

  assign a = x_i[1] ^ x_i[2] ^ x_i[3] ^ rk_i;
  assign b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};

  always_comb begin
    y_o = x_i[0] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    if (is_key_i) y_o = x_i[0] ^ b ^ rol(b, 13) ^ rol(b, 23);
  end

endmodule

// File: rtl/sm4_mode_engine.sv
// SM4 block engine with ECB/CBC/CTR chaining, unroll_p rounds per cycle and a one-entry key cache.
// CTR mode is present only when SM4_CTR_MODE_EN is defined; otherwise mode 10 runs as ECB.
module sm4_mode_engine
  import sm4_mode_engine_pkg::*;
#(
  parameter int unroll_p    = 1,
  parameter int ctr_width_p = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [group_size_p-1:0] content_i,
  input  logic [group_size_p-1:0] key_i,
  input  logic [group_size_p-1:0] iv_i,
  input  logic [1:0]              mode_i,
  input  logic                    decode_i,
  input  logic                    first_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [group_size_p-1:0] crypt_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  input  logic                    invalid_cache_i
);

  if (!(unroll_p == 1 || unroll_p == 2 || unroll_p == 4 || unroll_p == 8)) begin : g_bad_unroll
    $error("sm4_mode_engine: unroll_p must be 1, 2, 4 or 8");
  end

  localparam int n_lp = 32 / unroll_p;

  state_e           state_q;
  mode_e            mode_q, mode_in;
  logic [4:0]       cnt_q;
  logic [3:0][31:0] w_q, w_n;
  logic [31:0]      rk_q [32];
  logic [127:0]     key_q, content_q, chain_q, crypt_q, ctr_val;
  logic [127:0]     chain_in, ctr_in, x0_in, x0_reg, res;
  logic             dec_q, key_v_q, inv_seen_q;
  logic             accept, hit, last, is_key, rev;

  function automatic mode_e mode_eff(input logic [1:0] m);
`ifdef SM4_CTR_MODE_EN
    if (m == 2'b10) return eCTR;
`endif
    return (m == 2'b01) ? eCBC : eECB;
  endfunction

  function automatic logic [127:0] x0_f(input mode_e m, input logic dec,
                                        input logic [127:0] c, input logic [127:0] ch,
                                        input logic [127:0] ct);
    if (m == eCTR) return ct;
    if (m == eCBC && !dec) return c ^ ch;
    return c;
  endfunction

  assign ready_o  = (state_q == eIdle);
  assign v_o      = (state_q == eDone);
  assign crypt_o  = crypt_q;
  assign accept   = v_i & ready_o;
  assign hit      = key_v_q & (key_i == key_q) & ~invalid_cache_i;
  assign last     = (cnt_q == 5'(n_lp - 1));
  assign is_key   = (state_q == eKeyExp);
  assign rev      = dec_q & (mode_q != eCTR);
  assign mode_in  = mode_eff(mode_i);
  assign chain_in = first_i ? iv_i : chain_q;
  assign ctr_in   = first_i ? iv_i : ctr_val;
  assign x0_in    = x0_f(mode_in, decode_i, content_i, chain_in, ctr_in);
  assign x0_reg   = x0_f(mode_q, dec_q, content_q, chain_q, ctr_val);

  // Key expansion and data rounds share the same round chain.
  logic [3:0][31:0] lane_w [unroll_p+1];
  assign lane_w[0] = w_q;
  for (genvar j = 0; j < unroll_p; j++) begin : g_round
    logic [4:0]  idx;
    logic [31:0] rk, y;
    assign idx = 5'(int'(cnt_q) * unroll_p + j);
    assign rk  = is_key ? key_aux(idx) : rk_q[rev ? ~idx : idx];
    sm4_round u_round (.x_i(lane_w[j]), .rk_i(rk), .is_key_i(is_key), .y_o(y));
    assign lane_w[j+1] = {y, lane_w[j][3:1]};
  end
  assign w_n = lane_w[unroll_p];

  always_comb begin
    res = w_n;
    if (mode_q == eCBC && dec_q) res = w_n ^ chain_q;
    if (mode_q == eCTR)          res = w_n ^ content_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= eIdle;
      mode_q     <= eECB;
      cnt_q      <= '0;
      w_q        <= '0;
      key_q      <= '0;
      content_q  <= '0;
      chain_q    <= '0;
      crypt_q    <= '0;
      dec_q      <= 1'b0;
      key_v_q    <= 1'b0;
      inv_seen_q <= 1'b0;
      for (int i = 0; i < 32; i++) rk_q[i] <= '0;
    end else begin
      case (state_q)
        eIdle: if (accept) begin
          content_q <= content_i;
          mode_q    <= mode_in;
          dec_q     <= decode_i;
          key_q     <= key_i;
          cnt_q     <= '0;
          if (first_i) chain_q <= iv_i;
          if (hit) begin
            state_q <= eCrypt;
            w_q     <= to_words(x0_in);
          end else begin
            state_q    <= eKeyExp;
            w_q        <= to_words(key_i ^ key_xor_mask);
            key_v_q    <= 1'b0;
            inv_seen_q <= 1'b0;
          end
        end
        eKeyExp: begin
          for (int j = 0; j < unroll_p; j++) rk_q[5'(int'(cnt_q) * unroll_p + j)] <= lane_w[j+1][3];
          if (invalid_cache_i) inv_seen_q <= 1'b1;
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            state_q <= eCrypt;
            cnt_q   <= '0;
            w_q     <= to_words(x0_reg);
            key_v_q <= ~inv_seen_q;
          end else begin
            w_q <= w_n;
          end
        end
        eCrypt: begin
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            state_q <= eDone;
            cnt_q   <= '0;
            crypt_q <= res;
            if (mode_q == eCBC) chain_q <= dec_q ? content_q : w_n;
          end else begin
            w_q <= w_n;
          end
        end
        eDone: if (yumi_i) state_q <= eIdle;
        default: state_q <= eIdle;
      endcase
      // Invalidate wins over any cache fill in the same cycle.
      if (invalid_cache_i) key_v_q <= 1'b0;
    end
  end

`ifdef SM4_CTR_MODE_EN
  localparam logic [127:0] ctr_mask_lp = {128{1'b1}} >> (128 - ctr_width_p);
  logic [127:0] ctr_q;
  assign ctr_val = ctr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) ctr_q <= '0;
    else if (accept && first_i) ctr_q <= iv_i;
    else if (state_q == eCrypt && last && mode_q == eCTR)
      ctr_q <= (ctr_q & ~ctr_mask_lp) | ((ctr_q + 128'd1) & ctr_mask_lp);
  end
`else
  assign ctr_val = '0;
`endif

endmodule

// File: tb/tb_sm4_mode_engine.sv
// Directed bench: three engines (unroll 1/4/8, the last with a 32-bit counter) against known vectors and a reference model.
module tb_sm4_mode_engine;
  import sm4_mode_engine_pkg::*;

  localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C1 = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [1:0] ECB = 2'b00, CBC = 2'b01, CTR = 2'b10, RSV = 2'b11;

  logic clk, rst_n;
  logic [127:0] content [3], key [3], iv [3], crypt [3];
  logic [1:0] mode [3];
  logic dec [3], first [3], v [3], rdy [3], vo [3], yumi [3], inv [3];
  int total, bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sm4_mode_engine #(.unroll_p(g == 0 ? 1 : (g == 1 ? 4 : 8)), .ctr_width_p(g == 2 ? 32 : 128)) u_dut (
      .clk_i(clk), .reset_ni(rst_n), .content_i(content[g]), .key_i(key[g]), .iv_i(iv[g]),
      .mode_i(mode[g]), .decode_i(dec[g]), .first_i(first[g]), .v_i(v[g]), .ready_o(rdy[g]),
      .crypt_o(crypt[g]), .v_o(vo[g]), .yumi_i(yumi[g]), .invalid_cache_i(inv[g]));
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rl(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] tb_tau(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[a[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_sm4(input logic [127:0] k_in, input logic [127:0] blk, input bit d);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] t, ck;
    logic [127:0] fm;
    fm = key_xor_mask;
    for (int i = 0; i < 4; i++) begin
      k[i] = k_in[127-32*i -: 32] ^ fm[127-32*i -: 32];
      x[i] = blk[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int b = 0; b < 4; b++) ck[31-8*b -: 8] = 8'((4*i + b) * 7);
      t = tb_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rl(t, 13) ^ rl(t, 23);
    end
    for (int i = 0; i < 32; i++) begin
      t = tb_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (d ? k[35-i] : k[i+4]));
      x[i+4] = x[i] ^ t ^ rl(t, 2) ^ rl(t, 10) ^ rl(t, 18) ^ rl(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // One block: accept, optional invalidate pulse at cycle inv_at, optional hold in eDone, then consume.
  task automatic run_block(input int d, input logic [127:0] k_in, input logic [127:0] blk,
                           input logic [127:0] ivv, input logic [1:0] md, input logic dc,
                           input logic fs, input int inv_at, input int hold,
                           output logic [127:0] res, output int lat);
    content[d] = blk; key[d] = k_in; iv[d] = ivv; mode[d] = md; dec[d] = dc; first[d] = fs;
    v[d] = 1'b1;
    tick();
    v[d] = 1'b0; first[d] = 1'b0;
    lat = 1;
    while (!vo[d] && lat < 200) begin
      if (lat == inv_at) inv[d] = 1'b1;
      tick();
      inv[d] = 1'b0;
      lat++;
    end
    res = crypt[d];
    for (int h = 0; h < hold; h++) begin
      chk("hold_v", 128'(vo[d]), 128'd1);
      chk("hold_rdy", 128'(rdy[d]), 128'd0);
      chk("hold_dat", crypt[d], res);
      tick();
    end
    yumi[d] = 1'b1;
    tick();
    yumi[d] = 1'b0;
  endtask

  logic [127:0] r, c2, ones;
  int lat;

  initial begin
    clk = 1'b0; rst_n = 1'b0; total = 0; bad = 0;
    ones = {128{1'b1}};
    for (int d = 0; d < 3; d++) begin
      content[d] = '0; key[d] = '0; iv[d] = '0; mode[d] = ECB;
      dec[d] = 1'b0; first[d] = 1'b0; v[d] = 1'b0; yumi[d] = 1'b0; inv[d] = 1'b0;
    end
    repeat (3) tick();
    chk("rst_rdy", 128'(rdy[0]), 128'd1);
    chk("rst_v", 128'(vo[0]), 128'd0);
    chk("rst_dat", crypt[0], 128'd0);
    rst_n = 1'b1;
    tick();

    run_block(0, K, P1, '0, ECB, 1'b0, 1'b0, -1, 0, r, lat);
    chk("ecb_enc_miss", r, C1);
    chk("ecb_miss_lat", 128'(lat), 128'd65);
    run_block(0, K, P1, '0, ECB, 1'b0, 1'b0, -1, 0, r, lat);
    chk("ecb_enc_hit", r, C1);
    chk("ecb_hit_lat", 128'(lat), 128'd33);
    run_block(0, K, C1, '0, ECB, 1'b1, 1'b0, -1, 0, r, lat);
    chk("ecb_dec", r, P1);
    chk("ecb_dec_lat", 128'(lat), 128'd33);

    run_block(1, K, C1, '0, ECB, 1'b1, 1'b0, -1, 0, r, lat);
    chk("u4_dec_miss", r, P1);
    chk("u4_miss_lat", 128'(lat), 128'd17);
    run_block(1, K, C1, '0, ECB, 1'b1, 1'b0, -1, 0, r, lat);
    chk("u4_dec_hit", r, P1);
    chk("u4_hit_lat", 128'(lat), 128'd9);

    run_block(0, K, P1, '0, CBC, 1'b0, 1'b1, -1, 0, r, lat);
    chk("cbc_enc_c1", r, C1);
    run_block(0, K, '0, ones, CBC, 1'b0, 1'b0, -1, 0, c2, lat);
    chk("cbc_enc_c2", c2, ref_sm4(K, C1, 1'b0));
    run_block(0, K, C1, '0, CBC, 1'b1, 1'b1, -1, 0, r, lat);
    chk("cbc_dec_p1", r, P1);
    run_block(0, K, c2, ones, CBC, 1'b1, 1'b0, -1, 0, r, lat);
    chk("cbc_dec_p2", r, '0);

    run_block(2, K, P1, '0, RSV, 1'b0, 1'b0, -1, 0, r, lat);
    chk("rsvd_as_ecb", r, C1);
    chk("u8_miss_lat", 128'(lat), 128'd9);

`ifdef SM4_CTR_MODE_EN
    run_block(0, K, P1, ones, CTR, 1'b0, 1'b1, -1, 0, r, lat);
    chk("ctr_blk0", r, ref_sm4(K, ones, 1'b0) ^ P1);
    run_block(0, K, C1, '0, CTR, 1'b1, 1'b0, -1, 0, r, lat);
    chk("ctr_wrap128", r, ref_sm4(K, '0, 1'b0) ^ C1);
    run_block(2, K, P1, ones, CTR, 1'b0, 1'b1, -1, 0, r, lat);
    chk("ctr32_blk0", r, ref_sm4(K, ones, 1'b0) ^ P1);
    run_block(2, K, P1, '0, CTR, 1'b0, 1'b0, -1, 0, r, lat);
    chk("ctr32_wrap", r, ref_sm4(K, {{96{1'b1}}, 32'h0}, 1'b0) ^ P1);
`else
    run_block(0, K, P1, ones, CTR, 1'b0, 1'b1, -1, 0, r, lat);
    chk("ctr_off_ecb", r, C1);
`endif

    run_block(0, K2, P1, '0, ECB, 1'b0, 1'b0, 10, 0, r, lat);
    chk("inv_mid_res", r, ref_sm4(K2, P1, 1'b0));
    chk("inv_mid_lat", 128'(lat), 128'd65);
    run_block(0, K2, P1, '0, ECB, 1'b0, 1'b0, -1, 0, r, lat);
    chk("inv_next_miss", 128'(lat), 128'd65);
    run_block(0, K2, C1, '0, ECB, 1'b0, 1'b0, -1, 10, r, lat);
    chk("k2_hit_res", r, ref_sm4(K2, C1, 1'b0));
    chk("k2_hit_lat", 128'(lat), 128'd33);

    content[0] = P1; key[0] = K2; mode[0] = ECB; dec[0] = 1'b0; v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_v", 128'(vo[0]), 128'd0);
    chk("rst_mid_rdy", 128'(rdy[0]), 128'd1);
    chk("rst_mid_dat", crypt[0], '0);
    rst_n = 1'b1;
    tick();
    run_block(0, K2, P1, '0, ECB, 1'b0, 1'b0, -1, 0, r, lat);
    chk("rst_cache_miss", 128'(lat), 128'd65);
    chk("rst_after_res", r, ref_sm4(K2, P1, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
